// File: rtl/wb_select_unit.sv
// Write-back source selector: registered mux over NSRC sources, one of which is served by an I/O request/ack handshake.
// Define WB_SELECT_TIMEOUT_EN to build the I/O wait counter and timeout_err; without it IO_WAIT waits indefinitely.
module wb_select_unit #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 4,
  parameter int IO_SRC  = 1,
  parameter int TIMEOUT = 255,
  localparam int SELW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      io_data,
  input  logic                  io_ack,
  output logic                  io_req,
  output logic                  stall_out,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  wb_valid,
  output logic                  timeout_err
);

  typedef enum logic {IDLE, IO_WAIT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] src_sel;
  logic [WIDTH-1:0] load_val;
  logic             load;
  logic             is_io;

  // Out-of-range selects fall through to the last source.
  always_comb begin
    src_sel = src_data[(NSRC-1)*WIDTH +: WIDTH];
    for (int k = 0; k < NSRC-1; k++)
      if (sel == SELW'(k)) src_sel = src_data[k*WIDTH +: WIDTH];
  end

  assign is_io     = (sel == SELW'(IO_SRC));
  assign stall_out = (state == IO_WAIT);

`ifdef WB_SELECT_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        to_hit;
  logic        to_nx;

  assign to_hit = (wait_cnt == 16'(TIMEOUT));

  // Cleared in IDLE so every transfer starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (state == IDLE)   wait_cnt <= '0;
    else if (!io_ack)         wait_cnt <= wait_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_err <= 1'b0;
    else        timeout_err <= to_nx;
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
`ifdef WB_SELECT_TIMEOUT_EN
    to_nx    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_io) begin
            state_nx = IO_WAIT;
          end else begin
            load     = 1'b1;
            load_val = src_sel;
          end
        end
      end
      IO_WAIT: begin
        // A same-cycle ack beats the timeout.
        if (io_ack) begin
          load     = 1'b1;
          load_val = io_data;
          state_nx = IDLE;
        end
`ifdef WB_SELECT_TIMEOUT_EN
        else if (to_hit) begin
          load     = 1'b1;
          to_nx    = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      io_req   <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else begin
      state    <= state_nx;
      io_req   <= (state_nx == IO_WAIT);
      wb_valid <= load;
      if (load) wb_data <= load_val;
    end
  end

endmodule
